armleocpu_writeback: RTL and testbench
======================================

// Module: armleocpu_writeback
// PURPOSE
//  Writeback stage, directly downstream of the memory stage. Registers the memory stage's
//  rd result (one pipeline register), drives the register-file write port and exposes the
//  in-flight write for operand forwarding into decode/execute. Counts retired instructions
//  (minstret) and offers CSR read/write access to that counter.
// PARAMETERS
//  INSTRET_WIDTH  64  minstret counter width, legal 33..64; bits above INSTRET_WIDTH read 0
// PORTS
//  clk                 in   1   clock, all state on rising edge
//  rst                 in   1   asynchronous, active-high reset
//  m2wb_instr_valid    in   1   memory stage holds a valid instruction
//  m2wb_stall          in   1   memory stage stall_o; instruction not finished this cycle
//  m2wb_kill           in   1   memory stage raised an exception; instruction must not retire
//  m2wb_rd_write       in   1   instruction writes rd
//  m2wb_rd_waddr       in   5   destination register
//  m2wb_rd_wdata       in   32  destination data
//  m2wb_pc             in   32  pc of the instruction (trace only)
//  m2wb_instr          in   32  instruction word (trace only)
//  p2wb_flush          in   1   pipeline flush; drops instruction being captured this cycle
//  csr_instret_inhibit in   1   mcountinhibit.IR; 1 freezes counter increments
//  csr_instret_we_lo   in   1   write instret[31:0] with csr_instret_wdata
//  csr_instret_we_hi   in   1   write instret[63:32] with csr_instret_wdata
//  csr_instret_wdata   in   32  CSR write data
//  csr_instret         out  64  current counter value (zero-extended)
//  rf_write            out  1   register file write enable
//  rf_waddr            out  5   register file write address
//  rf_wdata            out  32  register file write data
//  wb_fwd_valid        out  1   forwarding source valid (== rf_write)
//  wb_fwd_addr         out  5   forwarded register index
//  wb_fwd_data         out  32  forwarded value
//  wb_retire           out  1   one-cycle pulse: an instruction retired this cycle
// BEHAVIOUR
//  - Capture: accept = m2wb_instr_valid & !m2wb_stall & !m2wb_kill & !p2wb_flush.
//    On accept register wb_valid=1, rd_write, waddr, wdata, pc, instr; else wb_valid=0 (bubble).
//  - Latency: exactly 1 cycle from accepted memory-stage result to rf_write/wb_retire.
//  - rf_write = wb_valid & wb_rd_write & (wb_waddr != 0); x0 is never written.
//  - rf_waddr/rf_wdata/wb_fwd_* are the registered values; fwd_valid==rf_write always.
//  - wb_retire = wb_valid (regardless of rd_write; stores/branches retire too).
//  - Counter: next = instret + 1 when wb_retire & !csr_instret_inhibit, wraps to 0 at
//    2^INSTRET_WIDTH-1. CSR write has priority over increment in the same cycle: written
//    half takes wdata, other half keeps its old value (no carry applied that cycle).
//  - we_lo & we_hi same cycle: both halves take wdata.
//  - Reset (asynchronous, any time incl. mid-capture): wb_valid=0, rf_write=0, rf_waddr=0,
//    rf_wdata=0, wb_fwd_*=0, wb_retire=0, csr_instret=0, trace outputs 0.
//  - No stall output: the stage always completes in one cycle and never back-pressures.
// CONFIGURATION
//  ARMLEOCPU_WB_TRACE_EN defined: adds outputs trace_valid(1), trace_pc(32), trace_instr(32),
//   trace_rd_write(1), trace_rd_waddr(5), trace_rd_wdata(32), driven from the wb register;
//   trace_valid == wb_retire.
//  Not defined: ports absent, pc/instr not registered; all other behaviour identical.
// TESTING
//  1. Reset asserted mid-cycle with wb_valid=1 -> all outputs 0 immediately, instret=0.
//  2. Valid ADD x5=0x1234, no stall -> next cycle rf_write=1, waddr=5, wdata=0x1234, retire=1.
//  3. Result to x0 -> rf_write=0, wb_retire=1, instret increments by 1.
//  4. m2wb_stall=1 for 3 cycles then 0 -> exactly one retire pulse, after stall drops.
//  5. m2wb_kill=1 or p2wb_flush=1 with valid -> rf_write=0, retire=0, instret unchanged.
//  6. instret=0x0000_0000_FFFF_FFFF, retire -> 0x1_0000_0000; retire with we_lo wdata=7 same
//     cycle -> 0x1_0000_0007; inhibit=1 with retire -> unchanged.

Source files
------------

// File: rtl/armleocpu_writeback_if.sv
// Memory-stage to writeback-stage result bundle.
// master: memory stage drives; slave: writeback consumes.
interface armleocpu_writeback_if;
  logic        instr_valid;
  logic        stall;
  logic        kill;
  logic        rd_write;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic [31:0] pc;
  logic [31:0] instr;

  modport master (
    output instr_valid, stall, kill,
    output rd_write, rd_waddr, rd_wdata,
    output pc, instr
  );

  modport slave (
    input instr_valid, stall, kill,
    input rd_write, rd_waddr, rd_wdata,
    input pc, instr
  );
endinterface

// File: rtl/armleocpu_writeback.sv
// Writeback stage: rd pipeline register, rf write/forward, minstret.
// Optional ARMLEOCPU_WB_TRACE_EN adds registered trace outputs.
module armleocpu_writeback #(
  parameter int INSTRET_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  armleocpu_writeback_if.slave        m2wb,
  input  logic                        p2wb_flush,
  input  logic                        csr_instret_inhibit,
  input  logic                        csr_instret_we_lo,
  input  logic                        csr_instret_we_hi,
  input  logic [31:0]                 csr_instret_wdata,
  output logic [63:0]                 csr_instret,
  output logic                        rf_write,
  output logic [4:0]                  rf_waddr,
  output logic [31:0]                 rf_wdata,
  output logic                        wb_fwd_valid,
  output logic [4:0]                  wb_fwd_addr,
  output logic [31:0]                 wb_fwd_data,
  output logic                        wb_retire
`ifdef ARMLEOCPU_WB_TRACE_EN
  ,
  output logic                        trace_valid,
  output logic [31:0]                 trace_pc,
  output logic [31:0]                 trace_instr,
  output logic                        trace_rd_write,
  output logic [4:0]                  trace_rd_waddr,
  output logic [31:0]                 trace_rd_wdata
`endif
);

  localparam int W = INSTRET_WIDTH;

  logic          r_wb_valid;
  logic          r_rd_write;
  logic [4:0]    r_waddr;
  logic [31:0]   r_wdata;
  logic [W-1:0]  r_instret;

  logic          w_accept;
  logic          w_rf_write;
  logic [63:0]   w_cnt_cur;
  logic [63:0]   w_cnt_next;

  assign w_accept = m2wb.instr_valid & ~m2wb.stall &
                    ~m2wb.kill & ~p2wb_flush;

  // Capture the memory-stage result; anything not accepted is a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_rd_write <= 1'b0;
      r_waddr    <= 5'd0;
      r_wdata    <= 32'd0;
    end else begin
      r_wb_valid <= w_accept;
      if (w_accept) begin
        r_rd_write <= m2wb.rd_write;
        r_waddr    <= m2wb.rd_waddr;
        r_wdata    <= m2wb.rd_wdata;
      end
    end
  end

`ifdef ARMLEOCPU_WB_TRACE_EN
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  // Trace-only fields travel alongside the rd result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= 32'd0;
      r_instr <= 32'd0;
    end else if (w_accept) begin
      r_pc    <= m2wb.pc;
      r_instr <= m2wb.instr;
    end
  end

  assign trace_valid    = r_wb_valid;
  assign trace_pc       = r_pc;
  assign trace_instr    = r_instr;
  assign trace_rd_write = r_rd_write;
  assign trace_rd_waddr = r_waddr;
  assign trace_rd_wdata = r_wdata;
`else
  logic w_unused_trace;
  assign w_unused_trace = ^{m2wb.pc, m2wb.instr};
`endif

  assign w_rf_write   = r_wb_valid & r_rd_write & (r_waddr != 5'd0);
  assign rf_write     = w_rf_write;
  assign rf_waddr     = r_waddr;
  assign rf_wdata     = r_wdata;
  assign wb_fwd_valid = w_rf_write;
  assign wb_fwd_addr  = r_waddr;
  assign wb_fwd_data  = r_wdata;
  assign wb_retire    = r_wb_valid;

  // Counter next value: CSR write beats increment, no carry on write
  always_comb begin
    w_cnt_cur  = 64'(r_instret);
    w_cnt_next = w_cnt_cur;
    if (csr_instret_we_lo | csr_instret_we_hi) begin
      if (csr_instret_we_lo)
        w_cnt_next[31:0] = csr_instret_wdata;
      if (csr_instret_we_hi)
        w_cnt_next[63:32] = csr_instret_wdata;
    end else if (r_wb_valid & ~csr_instret_inhibit) begin
      w_cnt_next = 64'(r_instret + W'(1));
    end
  end

  // minstret register, truncated to its configured width
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_instret <= '0;
    else
      r_instret <= w_cnt_next[W-1:0];
  end

  assign csr_instret = w_cnt_cur;

endmodule

// File: tb/tb_armleocpu_writeback.sv
// Testbench for armleocpu_writeback: vector table, corner
// sequences and randomized traffic against a reference model.
module tb_armleocpu_writeback;

  localparam int W = 64;
  localparam logic [63:0] MASK = ~64'd0 >> (64 - W);

  logic        clk;
  logic        rst;
  logic        p2wb_flush;
  logic        csr_instret_inhibit;
  logic        csr_instret_we_lo;
  logic        csr_instret_we_hi;
  logic [31:0] csr_instret_wdata;
  logic [63:0] csr_instret;
  logic        rf_write;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_addr;
  logic [31:0] wb_fwd_data;
  logic        wb_retire;
`ifdef ARMLEOCPU_WB_TRACE_EN
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;
  logic        trace_rd_write;
  logic [4:0]  trace_rd_waddr;
  logic [31:0] trace_rd_wdata;
`endif

  armleocpu_writeback_if m2wb_if ();

  armleocpu_writeback #(.INSTRET_WIDTH(W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .m2wb                (m2wb_if.slave),
    .p2wb_flush          (p2wb_flush),
    .csr_instret_inhibit (csr_instret_inhibit),
    .csr_instret_we_lo   (csr_instret_we_lo),
    .csr_instret_we_hi   (csr_instret_we_hi),
    .csr_instret_wdata   (csr_instret_wdata),
    .csr_instret         (csr_instret),
    .rf_write            (rf_write),
    .rf_waddr            (rf_waddr),
    .rf_wdata            (rf_wdata),
    .wb_fwd_valid        (wb_fwd_valid),
    .wb_fwd_addr         (wb_fwd_addr),
    .wb_fwd_data         (wb_fwd_data),
    .wb_retire           (wb_retire)
`ifdef ARMLEOCPU_WB_TRACE_EN
    ,
    .trace_valid         (trace_valid),
    .trace_pc            (trace_pc),
    .trace_instr         (trace_instr),
    .trace_rd_write      (trace_rd_write),
    .trace_rd_waddr      (trace_rd_waddr),
    .trace_rd_wdata      (trace_rd_wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: the instruction sitting in writeback
  logic        m_valid;
  logic        m_rdw;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [63:0] m_cnt;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic ew;
    ew = m_valid && m_rdw && (m_addr != 5'd0);
    chk("rf_write", 64'(rf_write), 64'(ew));
    chk("fwd_valid", 64'(wb_fwd_valid), 64'(ew));
    chk("retire", 64'(wb_retire), 64'(m_valid));
    chk("instret", csr_instret, m_cnt);
    if (ew) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(m_addr));
      chk("rf_wdata", 64'(rf_wdata), 64'(m_data));
      chk("fwd_addr", 64'(wb_fwd_addr), 64'(m_addr));
      chk("fwd_data", 64'(wb_fwd_data), 64'(m_data));
    end
`ifdef ARMLEOCPU_WB_TRACE_EN
    chk("trace_valid", 64'(trace_valid), 64'(m_valid));
`endif
  endtask

  // drive one cycle of inputs, clock it, advance model, check
  task automatic step(input logic v, input logic s,
                      input logic k, input logic f,
                      input logic rdw, input logic [4:0] a,
                      input logic [31:0] d, input logic inh,
                      input logic wlo, input logic whi,
                      input logic [31:0] wd);
    logic acc;
    m2wb_if.instr_valid = v;
    m2wb_if.stall       = s;
    m2wb_if.kill        = k;
    m2wb_if.rd_write    = rdw;
    m2wb_if.rd_waddr    = a;
    m2wb_if.rd_wdata    = d;
    m2wb_if.pc          = d ^ 32'h1000;
    m2wb_if.instr       = ~d;
    p2wb_flush          = f;
    csr_instret_inhibit = inh;
    csr_instret_we_lo   = wlo;
    csr_instret_we_hi   = whi;
    csr_instret_wdata   = wd;
    @(posedge clk);
    if (wlo || whi) begin
      if (wlo) m_cnt[31:0]  = wd;
      if (whi) m_cnt[63:32] = wd;
      m_cnt = m_cnt & MASK;
    end else if (m_valid && !inh) begin
      m_cnt = (m_cnt + 64'd1) & MASK;
    end
    acc = v && !s && !k && !f;
    m_valid = acc;
    if (acc) begin
      m_rdw  = rdw;
      m_addr = a;
      m_data = d;
    end
    #1;
    check_model();
  endtask

  task automatic idle(input logic inh);
    step(0, 0, 0, 0, 0, 5'd0, 32'd0, inh, 0, 0, 32'd0);
  endtask

  task automatic csr_wr(input logic lo, input logic hi,
                        input logic [31:0] wd);
    step(0, 0, 0, 0, 0, 5'd0, 32'd0, 0, lo, hi, wd);
  endtask

  task automatic issue(input logic [4:0] a, input logic [31:0] d);
    step(1, 0, 0, 0, 1, a, d, 0, 0, 0, 32'd0);
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_rdw   = 0;
    m_addr  = 0;
    m_data  = 0;
    m_cnt   = 0;
  endtask

  typedef struct {
    logic        v, s, k, f, rdw;
    logic [4:0]  a;
    logic [31:0] d;
    logic        e_write, e_retire;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t tbl[8];
  int pulses;

  initial begin
    tbl[0] = '{1,0,0,0,1,5'd5, 32'h1234,     1,1,64'd0};
    tbl[1] = '{1,0,0,0,1,5'd0, 32'h55,       0,1,64'd1};
    tbl[2] = '{1,0,0,0,0,5'd7, 32'h77,       0,1,64'd2};
    tbl[3] = '{1,0,1,0,1,5'd9, 32'h99,       0,0,64'd3};
    tbl[4] = '{1,0,0,1,1,5'd10,32'haa,       0,0,64'd3};
    tbl[5] = '{0,0,0,0,1,5'd11,32'hbb,       0,0,64'd3};
    tbl[6] = '{1,0,0,0,1,5'd31,32'hdeadbeef, 1,1,64'd3};
    tbl[7] = '{0,0,0,0,0,5'd0, 32'd0,        0,0,64'd4};

    model_reset();
    rst = 1'b1;
    m2wb_if.instr_valid = 0;
    m2wb_if.stall = 0;
    m2wb_if.kill = 0;
    m2wb_if.rd_write = 0;
    m2wb_if.rd_waddr = 0;
    m2wb_if.rd_wdata = 0;
    m2wb_if.pc = 0;
    m2wb_if.instr = 0;
    p2wb_flush = 0;
    csr_instret_inhibit = 0;
    csr_instret_we_lo = 0;
    csr_instret_we_hi = 0;
    csr_instret_wdata = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // asynchronous reset while a valid write is in writeback
    issue(5'd3, 32'hab);
    issue(5'd4, 32'hcd);
    chk("pre_rst_write", 64'(rf_write), 64'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_write", 64'(rf_write), 64'd0);
    chk("rst_retire", 64'(wb_retire), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_fwd", {wb_fwd_valid, wb_fwd_addr, wb_fwd_data}, 64'd0);
    chk("rst_instret", csr_instret, 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;

    // vector table from a clean reset
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].k, tbl[i].f, tbl[i].rdw,
           tbl[i].a, tbl[i].d, 0, 0, 0, 32'd0);
      chk($sformatf("tbl%0d_write", i), 64'(rf_write),
          64'(tbl[i].e_write));
      chk($sformatf("tbl%0d_retire", i), 64'(wb_retire),
          64'(tbl[i].e_retire));
      chk($sformatf("tbl%0d_cnt", i), csr_instret, tbl[i].e_cnt);
      if (tbl[i].e_write) begin
        chk($sformatf("tbl%0d_addr", i), 64'(rf_waddr),
            64'(tbl[i].a));
        chk($sformatf("tbl%0d_data", i), 64'(rf_wdata),
            64'(tbl[i].d));
      end
    end

    // stalled instruction retires once, after stall drops
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 1, 5'd6, 32'h600d, 0, 0, 0, 32'd0);
      if (wb_retire) pulses++;
    end
    chk("stall_no_retire", 64'(pulses), 64'd0);
    step(1, 0, 0, 0, 1, 5'd6, 32'h600d, 0, 0, 0, 32'd0);
    if (wb_retire) pulses++;
    idle(0);
    if (wb_retire) pulses++;
    chk("stall_one_retire", 64'(pulses), 64'd1);

    // counter carry across the 32-bit boundary
    csr_wr(1, 0, 32'hffff_ffff);
    csr_wr(0, 1, 32'h0);
    chk("cnt_preset", csr_instret, 64'h0000_0000_ffff_ffff);
    issue(5'd1, 32'h1);
    idle(0);
    chk("cnt_carry", csr_instret, 64'h1_0000_0000);
    issue(5'd1, 32'h2);
    csr_wr(1, 0, 32'd7);
    chk("cnt_wr_prio", csr_instret, 64'h1_0000_0007);
    issue(5'd1, 32'h3);
    idle(1);
    chk("cnt_inhibit", csr_instret, 64'h1_0000_0007);
    csr_wr(1, 1, 32'ha5);
    chk("cnt_both", csr_instret, 64'h0000_00a5_0000_00a5);
    csr_wr(1, 1, 32'hffff_ffff);
    issue(5'd2, 32'h4);
    idle(0);
    chk("cnt_wrap", csr_instret, 64'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] wd;
      wd = ($urandom_range(0, 1) == 0) ? 32'hffff_ffff : $urandom;
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0,
           1'($urandom),
           5'($urandom),
           $urandom,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0,
           wd);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
